pong_scene_gen: RTL

- Upstream stage of the pixel colour mixer. Generates 640x480@60 VGA timing from the 25 MHz pixel clock.
- Runs the per-frame game state: two paddles and a bouncing ball.
- Every pixel clock it emits the region flags BRPad1, BRPad2, BRBall, BRWall and BRIW, which the colour mixer turns into vga_red/green/blue. It also emits hsync/vsync aligned to those flags.

---
 rtl/pong_scene_gen.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/pong_scene_gen.sv
// pong_scene_gen: raster timing, paddle/ball game state and per-pixel region
// flags for the downstream colour mixer. Sync and flags are registered
// together so they leave the block with the same one-cycle latency.
module pong_scene_gen #(
  parameter int H_VIS     = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VIS     = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int WALL      = 8,
  parameter int PAD_W     = 8,
  parameter int PAD_H     = 64,
  parameter int PAD1_X    = 16,
  parameter int PAD2_X    = 616,
  parameter int BALL_SZ   = 8,
  parameter int PAD_STEP  = 4,
  parameter int BALL_STEP = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic up1,
  input  logic dn1,
  input  logic up2,
  input  logic dn2,
  output logic hsync,
  output logic vsync,
  output logic BRIW,
  output logic BRWall,
  output logic BRPad1,
  output logic BRPad2,
  output logic BRBall,
  output logic miss1,
  output logic miss2
);

  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0] HV       = 10'(H_VIS);
  localparam logic [9:0] VV       = 10'(V_VIS);
  localparam logic [9:0] WALL_TOP = 10'(WALL);
  localparam logic [9:0] WALL_BOT = 10'(V_VIS - WALL);
  localparam logic [9:0] PAD_MAX  = 10'(V_VIS - WALL - PAD_H);
  localparam logic [9:0] P1X      = 10'(PAD1_X);
  localparam logic [9:0] P2X      = 10'(PAD2_X);
  localparam logic [9:0] PW       = 10'(PAD_W);
  localparam logic [9:0] PH       = 10'(PAD_H);
  localparam logic [9:0] BS       = 10'(BALL_SZ);
  localparam logic [9:0] PST      = 10'(PAD_STEP);
  localparam logic [9:0] BST      = 10'(BALL_STEP);
  localparam logic [9:0] FACE1    = 10'(PAD1_X + PAD_W);
  localparam logic [9:0] FACE2    = 10'(PAD2_X - BALL_SZ);
  localparam logic [9:0] BX_MAX   = 10'(H_VIS - BALL_SZ);
  localparam logic [9:0] BY_MAX   = 10'(V_VIS - WALL - BALL_SZ);
  localparam logic [9:0] BY_TURN  = 10'(WALL + BALL_STEP);
  localparam logic [9:0] BX_HOME  = 10'((H_VIS - BALL_SZ) / 2);
  localparam logic [9:0] BY_HOME  = 10'((V_VIS - BALL_SZ) / 2);
  localparam logic [9:0] PY_HOME  = 10'((V_VIS - PAD_H) / 2);

  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [9:0] p1y_q, p1y_d, p2y_q, p2y_d;
  logic [9:0] bx_q, bx_d, by_q, by_d;
  logic       dx_q, dx_d;   // 1 = moving right
  logic       dy_q, dy_d;   // 1 = moving down
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       briw_q, briw_d, brwall_q, brwall_d;
  logic       brpad1_q, brpad1_d, brpad2_q, brpad2_d, brball_q, brball_d;
  logic       miss1_q, miss1_d, miss2_q, miss2_d;
  logic       tick, vis, ov1, ov2;

  // Clamped paddle move; both buttons or neither means hold.
  function automatic logic [9:0] pad_next(input logic [9:0] p, input logic up, input logic dn);
    logic [9:0] r;
    r = p;
    if (up && !dn) r = (p < WALL_TOP + PST) ? WALL_TOP : p - PST;
    if (dn && !up) r = (p + PST > PAD_MAX) ? PAD_MAX : p + PST;
    return r;
  endfunction

  // Raster counters and the end-of-frame tick.
  always_comb begin
    hcnt_d = hcnt_q + 10'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
    end
    tick = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
  end

  // Sync and region flags decoded from the current counters and positions.
  always_comb begin
    vis      = (hcnt_q < HV) && (vcnt_q < VV);
    hsync_d  = !((hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST));
    vsync_d  = !((vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST));
    briw_d   = vis;
    brwall_d = vis && ((vcnt_q < WALL_TOP) || (vcnt_q >= WALL_BOT));
    brpad1_d = vis && (hcnt_q >= P1X) && (hcnt_q < P1X + PW)
                   && (vcnt_q >= p1y_q) && (vcnt_q < p1y_q + PH);
    brpad2_d = vis && (hcnt_q >= P2X) && (hcnt_q < P2X + PW)
                   && (vcnt_q >= p2y_q) && (vcnt_q < p2y_q + PH);
    brball_d = vis && (hcnt_q >= bx_q) && (hcnt_q < bx_q + BS)
                   && (vcnt_q >= by_q) && (vcnt_q < by_q + BS);
  end

  // Game state: only changes on the frame tick; collisions use pre-tick paddles.
  always_comb begin
    p1y_d   = p1y_q;
    p2y_d   = p2y_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    miss1_d = 1'b0;
    miss2_d = 1'b0;
    ov1     = (by_q + BS > p1y_q) && (by_q < p1y_q + PH);
    ov2     = (by_q + BS > p2y_q) && (by_q < p2y_q + PH);
    if (tick) begin
      p1y_d = pad_next(p1y_q, up1, dn1);
      p2y_d = pad_next(p2y_q, up2, dn2);
      if (dy_q) begin
        if (by_q + BST > BY_MAX) begin
          by_d = BY_MAX;
          dy_d = 1'b0;
        end else begin
          by_d = by_q + BST;
        end
      end else begin
        if (by_q < BY_TURN) begin
          by_d = WALL_TOP;
          dy_d = 1'b1;
        end else begin
          by_d = by_q - BST;
        end
      end
      if (!dx_q) begin
        if ((bx_q >= FACE1) && (bx_q - BST < FACE1) && ov1) begin
          bx_d = FACE1;
          dx_d = 1'b1;
        end else if (bx_q < BST) begin
          miss1_d = 1'b1;
          bx_d    = BX_HOME;
          by_d    = BY_HOME;
          dx_d    = 1'b1;
          dy_d    = dy_q;
        end else begin
          bx_d = bx_q - BST;
        end
      end else begin
        if ((bx_q <= FACE2) && (bx_q + BST > FACE2) && ov2) begin
          bx_d = FACE2;
          dx_d = 1'b0;
        end else if (bx_q + BST > BX_MAX) begin
          miss2_d = 1'b1;
          bx_d    = BX_HOME;
          by_d    = BY_HOME;
          dx_d    = 1'b0;
          dy_d    = dy_q;
        end else begin
          bx_d = bx_q + BST;
        end
      end
    end
  end

  // All state, with asynchronous return to the centred start position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      p1y_q    <= PY_HOME;
      p2y_q    <= PY_HOME;
      bx_q     <= BX_HOME;
      by_q     <= BY_HOME;
      dx_q     <= 1'b1;
      dy_q     <= 1'b1;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      briw_q   <= 1'b0;
      brwall_q <= 1'b0;
      brpad1_q <= 1'b0;
      brpad2_q <= 1'b0;
      brball_q <= 1'b0;
      miss1_q  <= 1'b0;
      miss2_q  <= 1'b0;
    end else begin
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      p1y_q    <= p1y_d;
      p2y_q    <= p2y_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      briw_q   <= briw_d;
      brwall_q <= brwall_d;
      brpad1_q <= brpad1_d;
      brpad2_q <= brpad2_d;
      brball_q <= brball_d;
      miss1_q  <= miss1_d;
      miss2_q  <= miss2_d;
    end
  end

  assign hsync  = hsync_q;
  assign vsync  = vsync_q;
  assign BRIW   = briw_q;
  assign BRWall = brwall_q;
  assign BRPad1 = brpad1_q;
  assign BRPad2 = brpad2_q;
  assign BRBall = brball_q;
  assign miss1  = miss1_q;
  assign miss2  = miss2_q;

endmodule
